// File: rtl/wbswitch_rr_if.sv
// rtl/wbswitch_rr_if.sv - Wishbone master-side and slave-side signal bundle for wbswitch_rr
interface wbswitch_rr_if #(
  parameter int N_MASTERS = 4,
  parameter int N_SLAVES  = 6
);
  logic [32*N_MASTERS-1:0] m_adr_i;
  logic [32*N_MASTERS-1:0] m_dat_i;
  logic [4*N_MASTERS-1:0]  m_sel_i;
  logic [3*N_MASTERS-1:0]  m_cti_i;
  logic [N_MASTERS-1:0]    m_we_i;
  logic [N_MASTERS-1:0]    m_cyc_i;
  logic [N_MASTERS-1:0]    m_stb_i;
  logic [31:0]             m_dat_o;
  logic [N_MASTERS-1:0]    m_ack_o;
  logic [N_MASTERS-1:0]    m_err_o;
  logic [31:0]             s_adr_o;
  logic [31:0]             s_dat_o;
  logic [3:0]              s_sel_o;
  logic [2:0]              s_cti_o;
  logic                    s_we_o;
  logic [N_SLAVES-1:0]     s_cyc_o;
  logic [N_SLAVES-1:0]     s_stb_o;
  logic [32*N_SLAVES-1:0]  s_dat_i;
  logic [N_SLAVES-1:0]     s_ack_i;

  // The attached masters and slaves together drive the *_i side.
  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_we_i, m_cyc_i, m_stb_i, s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, m_err_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_we_o, s_cyc_o, s_stb_o
  );

  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_we_i, m_cyc_i, m_stb_i, s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, m_err_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_we_o, s_cyc_o, s_stb_o
  );
endinterface

// File: rtl/wbswitch_rr.sv
// rtl/wbswitch_rr.sv - round-robin Wishbone shared-bus switch with decode-miss errors and watchdog
module wbswitch_rr #(
  parameter int N_MASTERS = 4,
  parameter int N_SLAVES  = 6,
  parameter int S_ADDR_W  = 3,
  parameter logic [N_SLAVES*S_ADDR_W-1:0] S_ADDR = {3'b110, 3'b101, 3'b100, 3'b010, 3'b001, 3'b000},
  parameter int TIMEOUT   = 255
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  wbswitch_rr_if.slave         bus,
  output logic [N_MASTERS-1:0] grant_o,
  output logic                 timeout_o
);
  localparam int OW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

  typedef enum logic {IDLE, OWN} state_t;

  state_t              state;
  logic [OW-1:0]       owner;
  logic [OW-1:0]       last;
  logic [OW-1:0]       next_owner;
  logic [15:0]         wd_cnt;
  logic                err_q;
  logic                busy;
  logic                own_cyc;
  logic                own_stb;
  logic                any_hit;
  logic                sel_ack;
  logic                miss;
  logic                wd_fire;
  logic [31:0]         own_adr;
  logic [31:0]         sel_dat;
  logic [N_SLAVES-1:0] hit;
  logic [N_SLAVES-1:0] sel_oh;

  assign busy    = (state == OWN);
  assign own_cyc = busy & bus.m_cyc_i[owner];
  assign own_stb = busy & bus.m_stb_i[owner];
  assign own_adr = busy ? bus.m_adr_i[int'(owner)*32 +: 32] : 32'd0;

  // Scan downward so the closest requester after `last` is assigned last and wins.
  always_comb begin
    next_owner = last;
    for (int i = N_MASTERS; i >= 1; i--) begin
      if (bus.m_cyc_i[(int'(last) + i) % N_MASTERS])
        next_owner = OW'((int'(last) + i) % N_MASTERS);
    end
  end

  // Overlapping decode slices resolve to the lowest slave index.
  always_comb begin
    hit     = '0;
    sel_oh  = '0;
    sel_dat = 32'd0;
    sel_ack = 1'b0;
    for (int k = N_SLAVES-1; k >= 0; k--) begin
      hit[k] = busy && (own_adr[31 -: S_ADDR_W] == S_ADDR[k*S_ADDR_W +: S_ADDR_W]);
      if (hit[k]) begin
        sel_oh    = '0;
        sel_oh[k] = 1'b1;
        sel_dat   = bus.s_dat_i[k*32 +: 32];
        sel_ack   = bus.s_ack_i[k];
      end
    end
    any_hit = |hit;
  end

  assign miss    = own_stb & ~any_hit;
  assign wd_fire = (TIMEOUT != 0) && own_stb && any_hit && !sel_ack && !err_q && (wd_cnt == TO_CNT);

  assign bus.s_adr_o = own_adr;
  assign bus.s_dat_o = busy ? bus.m_dat_i[int'(owner)*32 +: 32] : 32'd0;
  assign bus.s_sel_o = busy ? bus.m_sel_i[int'(owner)*4 +: 4] : 4'd0;
  assign bus.s_cti_o = busy ? bus.m_cti_i[int'(owner)*3 +: 3] : 3'd0;
  assign bus.s_we_o  = busy & bus.m_we_i[owner];
  assign bus.s_cyc_o = own_cyc ? sel_oh : '0;
  assign bus.s_stb_o = (own_stb && !timeout_o) ? sel_oh : '0;
  assign bus.m_dat_o = sel_dat;
  assign bus.m_ack_o = sel_ack ? grant_o : '0;
  assign bus.m_err_o = err_q ? grant_o : '0;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      owner     <= '0;
      last      <= OW'(N_MASTERS-1);
      grant_o   <= '0;
      wd_cnt    <= 16'd0;
      err_q     <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      // Decode-miss errors alternate on/off while the strobe is held.
      err_q     <= (miss && !err_q) || wd_fire;
      timeout_o <= wd_fire;
      if (!own_stb || sel_ack || err_q || wd_fire)
        wd_cnt <= 16'd0;
      else
        wd_cnt <= wd_cnt + 16'd1;

      case (state)
        IDLE: begin
          if (|bus.m_cyc_i) begin
            state   <= OWN;
            owner   <= next_owner;
            last    <= next_owner;
            grant_o <= N_MASTERS'(1) << next_owner;
          end
        end
        OWN: begin
          if (!own_cyc) begin
            state     <= IDLE;
            grant_o   <= '0;
            err_q     <= 1'b0;
            timeout_o <= 1'b0;
            wd_cnt    <= 16'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wbswitch_rr.sv
// tb/tb_wbswitch_rr.sv - scoreboard bench for wbswitch_rr (4 masters, 6 slaves, TIMEOUT=15)
module tb_wbswitch_rr;
  localparam int NM = 4;
  localparam int NS = 6;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [NM-1:0] grant;
  logic          timeout;
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [31:0]   exp_dat_q[$];
  int            exp_gnt_q[$];

  wbswitch_rr_if #(.N_MASTERS(NM), .N_SLAVES(NS)) bus();

  wbswitch_rr #(
    .N_MASTERS(NM),
    .N_SLAVES(NS),
    .S_ADDR_W(3),
    .S_ADDR({3'b110, 3'b101, 3'b100, 3'b010, 3'b001, 3'b000}),
    .TIMEOUT(15)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus(bus),
    .grant_o(grant),
    .timeout_o(timeout)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge sys_clk);
  endtask

  task automatic clear_bus();
    bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0; bus.m_cti_i = '0;
    bus.m_we_i  = '0; bus.m_cyc_i = '0; bus.m_stb_i = '0;
    bus.s_dat_i = '0; bus.s_ack_i = '0;
  endtask

  task automatic do_reset();
    clear_bus();
    sys_rst = 1'b1;
    step();
    step();
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_bus();
    sys_rst = 1'b1;
    bus.m_cyc_i = '1;
    bus.m_stb_i = '1;
    step(); step(); sample();
    n_cmp++; if (grant !== 4'b0) begin n_bad++; $display("FAIL rst_grant: got %b expected 0000", grant); end
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL rst_timeout: got %b expected 0", timeout); end
    n_cmp++; if (bus.s_cyc_o !== 6'b0) begin n_bad++; $display("FAIL rst_s_cyc: got %b expected 000000", bus.s_cyc_o); end
    n_cmp++; if (bus.s_stb_o !== 6'b0) begin n_bad++; $display("FAIL rst_s_stb: got %b expected 000000", bus.s_stb_o); end
    n_cmp++; if (bus.m_ack_o !== 4'b0 || bus.m_err_o !== 4'b0) begin n_bad++; $display("FAIL rst_ack_err: got %b/%b expected 0000/0000", bus.m_ack_o, bus.m_err_o); end
    n_cmp++; if (bus.s_adr_o !== 32'h0 || bus.m_dat_o !== 32'h0) begin n_bad++; $display("FAIL rst_adr_dat: got %h/%h expected 0/0", bus.s_adr_o, bus.m_dat_o); end
    step();
    sys_rst = 1'b0;
    sample();
    n_cmp++; if (grant !== 4'b0) begin n_bad++; $display("FAIL rst_release_grant: got %b expected 0000", grant); end
    step(); sample();
    n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL rst_first_grant: got %b expected 0001", grant); end
    n_cmp++; if (bus.s_cyc_o !== 6'b000001) begin n_bad++; $display("FAIL rst_first_cyc: got %b expected 000001", bus.s_cyc_o); end
    clear_bus();
    step();
  endtask

  task automatic test_single_read();
    do_reset();
    bus.m_adr_i[31:0] = 32'h4000_0010;
    bus.m_sel_i[3:0]  = 4'hF;
    bus.m_cyc_i[0] = 1'b1;
    bus.m_stb_i[0] = 1'b1;
    exp_dat_q.push_back(32'hDEAD_BEEF);
    sample();
    n_cmp++; if (grant !== 4'b0) begin n_bad++; $display("FAIL rd_grant_c0: got %b expected 0000", grant); end
    step(); sample();
    n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL rd_grant_c1: got %b expected 0001", grant); end
    n_cmp++; if (bus.s_stb_o !== 6'b000100) begin n_bad++; $display("FAIL rd_s_stb: got %b expected 000100", bus.s_stb_o); end
    n_cmp++; if (bus.s_cyc_o !== 6'b000100) begin n_bad++; $display("FAIL rd_s_cyc: got %b expected 000100", bus.s_cyc_o); end
    n_cmp++; if (bus.s_adr_o !== 32'h4000_0010) begin n_bad++; $display("FAIL rd_s_adr: got %h expected 40000010", bus.s_adr_o); end
    step();
    bus.s_ack_i = 6'b001000;
    bus.s_dat_i[3*32 +: 32] = 32'h3333_3333;
    sample();
    n_cmp++; if (bus.m_ack_o !== 4'b0) begin n_bad++; $display("FAIL rd_stray_ack: got %b expected 0000", bus.m_ack_o); end
    step();
    bus.s_ack_i = 6'b000100;
    bus.s_dat_i[2*32 +: 32] = 32'hDEAD_BEEF;
    sample();
    n_cmp++; if (bus.m_ack_o !== 4'b0001) begin n_bad++; $display("FAIL rd_ack: got %b expected 0001", bus.m_ack_o); end
    n_cmp++;
    if (exp_dat_q.size() == 0) begin n_bad++; $display("FAIL rd_dat: scoreboard empty, got %h", bus.m_dat_o); end
    else begin
      logic [31:0] e;
      e = exp_dat_q.pop_front();
      if (bus.m_dat_o !== e) begin n_bad++; $display("FAIL rd_dat: got %h expected %h", bus.m_dat_o, e); end
    end
    step();
    clear_bus();
    step(); sample();
    n_cmp++; if (grant !== 4'b0) begin n_bad++; $display("FAIL rd_release: got %b expected 0000", grant); end
  endtask

  task automatic test_round_robin();
    logic [3:0] req, cur, prev_g, eg;
    int drop, acks, cur_owner;
    logic chk_gap;
    do_reset();
    bus.m_adr_i[0*32 +: 32] = 32'h0000_0100;
    bus.m_adr_i[1*32 +: 32] = 32'h2000_0100;
    bus.m_adr_i[3*32 +: 32] = 32'hC000_0100;
    for (int k = 0; k < NS; k++) bus.s_dat_i[k*32 +: 32] = 32'h5100_0000 + 32'(k);
    for (int r = 0; r < 2; r++) begin
      exp_gnt_q.push_back(0); exp_dat_q.push_back(32'h5100_0000);
      exp_gnt_q.push_back(1); exp_dat_q.push_back(32'h5100_0001);
      exp_gnt_q.push_back(3); exp_dat_q.push_back(32'h5100_0005);
    end
    req = 4'b1011; drop = -1; acks = 0; prev_g = '0; chk_gap = 1'b0; cur_owner = 0;
    for (int c = 0; c < 80 && acks < 6; c++) begin
      cur = req;
      if (drop >= 0) cur[drop] = 1'b0;
      bus.m_cyc_i = cur;
      bus.m_stb_i = cur;
      #1 bus.s_ack_i = bus.s_stb_o;
      sample();
      if (chk_gap) begin
        n_cmp++; if (grant !== 4'b0) begin n_bad++; $display("FAIL rr_gap: got %b expected 0000", grant); end
        chk_gap = 1'b0;
      end
      if (drop >= 0) begin chk_gap = 1'b1; drop = -1; end
      if (grant !== 4'b0 && prev_g === 4'b0) begin
        n_cmp++;
        if (exp_gnt_q.size() == 0) begin n_bad++; $display("FAIL rr_grant: extra grant %b", grant); end
        else begin
          cur_owner = exp_gnt_q.pop_front();
          eg = 4'b0001 << cur_owner;
          if (grant !== eg) begin n_bad++; $display("FAIL rr_grant: got %b expected %b", grant, eg); end
        end
      end
      if (bus.m_ack_o !== 4'b0) begin
        eg = 4'b0001 << cur_owner;
        n_cmp++; if (bus.m_ack_o !== eg) begin n_bad++; $display("FAIL rr_ack: got %b expected %b", bus.m_ack_o, eg); end
        n_cmp++;
        if (exp_dat_q.size() == 0) begin n_bad++; $display("FAIL rr_dat: scoreboard empty, got %h", bus.m_dat_o); end
        else begin
          logic [31:0] e;
          e = exp_dat_q.pop_front();
          if (bus.m_dat_o !== e) begin n_bad++; $display("FAIL rr_dat: got %h expected %h", bus.m_dat_o, e); end
        end
        acks++;
        drop = cur_owner;
      end
      prev_g = grant;
      step();
    end
    n_cmp++; if (acks != 6) begin n_bad++; $display("FAIL rr_budget: got %0d acks expected 6", acks); end
    exp_gnt_q.delete();
    exp_dat_q.delete();
    clear_bus();
    step();
  endtask

  task automatic test_decode_miss();
    do_reset();
    bus.s_dat_i = '1;
    bus.m_adr_i[31:0] = 32'h6000_0000;
    bus.m_cyc_i[0] = 1'b1;
    bus.m_stb_i[0] = 1'b1;
    step(); sample();
    n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL miss_grant: got %b expected 0001", grant); end
    n_cmp++; if (bus.s_stb_o !== 6'b0 || bus.s_cyc_o !== 6'b0) begin n_bad++; $display("FAIL miss_s_stb: got %b/%b expected 0", bus.s_stb_o, bus.s_cyc_o); end
    n_cmp++; if (bus.m_err_o !== 4'b0) begin n_bad++; $display("FAIL miss_err_c1: got %b expected 0000", bus.m_err_o); end
    n_cmp++; if (bus.m_dat_o !== 32'h0) begin n_bad++; $display("FAIL miss_dat: got %h expected 0", bus.m_dat_o); end
    step(); sample();
    n_cmp++; if (bus.m_err_o !== 4'b0001) begin n_bad++; $display("FAIL miss_err_c2: got %b expected 0001", bus.m_err_o); end
    n_cmp++; if (timeout !== 1'b0 || bus.m_ack_o !== 4'b0) begin n_bad++; $display("FAIL miss_to_ack: got %b/%b expected 0/0000", timeout, bus.m_ack_o); end
    step(); sample();
    n_cmp++; if (bus.m_err_o !== 4'b0) begin n_bad++; $display("FAIL miss_err_c3: got %b expected 0000", bus.m_err_o); end
    step(); sample();
    n_cmp++; if (bus.m_err_o !== 4'b0001) begin n_bad++; $display("FAIL miss_err_c4: got %b expected 0001", bus.m_err_o); end
    clear_bus();
    step();
  endtask

  task automatic test_watchdog();
    logic [3:0] e_err;
    logic [5:0] e_stb;
    logic       e_to;
    do_reset();
    bus.m_adr_i[31:0] = 32'hA000_0000;
    bus.m_cyc_i[0] = 1'b1;
    bus.m_stb_i[0] = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      step(); sample();
      e_err = (c == 17) ? 4'b0001 : 4'b0000;
      e_to  = (c == 17);
      e_stb = (c == 17) ? 6'b000000 : 6'b010000;
      n_cmp++; if (bus.m_err_o !== e_err) begin n_bad++; $display("FAIL wd_err c%0d: got %b expected %b", c, bus.m_err_o, e_err); end
      n_cmp++; if (timeout !== e_to) begin n_bad++; $display("FAIL wd_timeout c%0d: got %b expected %b", c, timeout, e_to); end
      n_cmp++; if (bus.s_stb_o !== e_stb) begin n_bad++; $display("FAIL wd_s_stb c%0d: got %b expected %b", c, bus.s_stb_o, e_stb); end
    end
    clear_bus();
    step();
  endtask

  task automatic test_ack_at_expiry();
    do_reset();
    bus.m_adr_i[31:0] = 32'hA000_0000;
    bus.m_cyc_i[0] = 1'b1;
    bus.m_stb_i[0] = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      step();
      if (c == 16) begin
        bus.s_ack_i = 6'b010000;
        bus.s_dat_i[4*32 +: 32] = 32'h0BAD_F00D;
        exp_dat_q.push_back(32'h0BAD_F00D);
      end else begin
        bus.s_ack_i = 6'b0;
      end
      sample();
      if (c == 16) begin
        n_cmp++; if (bus.m_ack_o !== 4'b0001) begin n_bad++; $display("FAIL exp_ack: got %b expected 0001", bus.m_ack_o); end
        n_cmp++;
        if (exp_dat_q.size() == 0) begin n_bad++; $display("FAIL exp_dat: scoreboard empty, got %h", bus.m_dat_o); end
        else begin
          logic [31:0] e;
          e = exp_dat_q.pop_front();
          if (bus.m_dat_o !== e) begin n_bad++; $display("FAIL exp_dat: got %h expected %h", bus.m_dat_o, e); end
        end
      end
      if (c == 17) begin
        n_cmp++; if (bus.m_err_o !== 4'b0) begin n_bad++; $display("FAIL exp_no_err: got %b expected 0000", bus.m_err_o); end
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL exp_no_timeout: got %b expected 0", timeout); end
      end
    end
    clear_bus();
    step();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.m_adr_i[2*32 +: 32] = 32'h2000_0000;
    bus.m_cti_i[2*3 +: 3]   = 3'b010;
    bus.m_cyc_i[2] = 1'b1;
    bus.m_stb_i[2] = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      bus.s_ack_i = 6'b000010;
      bus.s_dat_i[1*32 +: 32] = 32'hB000_0000 + 32'(c);
      exp_dat_q.push_back(32'hB000_0000 + 32'(c));
      if (c == 2) begin
        bus.m_cyc_i[0] = 1'b1; bus.m_stb_i[0] = 1'b1;
        bus.m_cyc_i[3] = 1'b1; bus.m_stb_i[3] = 1'b1;
      end
      sample();
      n_cmp++; if (grant !== 4'b0100) begin n_bad++; $display("FAIL burst_grant c%0d: got %b expected 0100", c, grant); end
      n_cmp++; if (bus.s_cti_o !== 3'b010) begin n_bad++; $display("FAIL burst_cti c%0d: got %b expected 010", c, bus.s_cti_o); end
      n_cmp++;
      if (bus.m_ack_o !== 4'b0100 || exp_dat_q.size() == 0) begin n_bad++; $display("FAIL burst_ack c%0d: got %b expected 0100", c, bus.m_ack_o); end
      else begin
        logic [31:0] e;
        e = exp_dat_q.pop_front();
        if (bus.m_dat_o !== e) begin n_bad++; $display("FAIL burst_dat c%0d: got %h expected %h", c, bus.m_dat_o, e); end
      end
    end
    step();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    sample();
    n_cmp++; if (grant !== 4'b0 || timeout !== 1'b0) begin n_bad++; $display("FAIL mrst_grant: got %b/%b expected 0000/0", grant, timeout); end
    n_cmp++; if (bus.s_cyc_o !== 6'b0 || bus.s_stb_o !== 6'b0) begin n_bad++; $display("FAIL mrst_s_ctl: got %b/%b expected 0/0", bus.s_cyc_o, bus.s_stb_o); end
    n_cmp++; if (bus.s_adr_o !== 32'h0 || bus.s_dat_o !== 32'h0 || bus.s_cti_o !== 3'b0) begin n_bad++; $display("FAIL mrst_s_bus: got %h/%h/%b expected 0", bus.s_adr_o, bus.s_dat_o, bus.s_cti_o); end
    n_cmp++; if (bus.m_ack_o !== 4'b0 || bus.m_err_o !== 4'b0 || bus.m_dat_o !== 32'h0) begin n_bad++; $display("FAIL mrst_m_bus: got %b/%b/%h expected 0", bus.m_ack_o, bus.m_err_o, bus.m_dat_o); end
    step(); sample();
    n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL mrst_first_grant: got %b expected 0001", grant); end
    exp_dat_q.delete();
    clear_bus();
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_decode_miss();
    test_watchdog();
    test_ack_at_expiry();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation still running at %0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/wbswitch_rr.md
# wbswitch_rr

Parametrised Wishbone shared-bus interconnect with round-robin arbitration, bus-error reporting and a transfer watchdog. It connects N_MASTERS masters to N_SLAVES address-decoded slaves. It sits between the LM32 I/D buses (plus DMA-capable peripherals such as future multi-channel TDC readout engines) and the memory/CSR/TDC slaves. Unlike the fixed 6x6 priority bus it generalises, the master/slave count and the decode map are parameters, and stuck or unmapped accesses terminate with an error instead of hanging the CPU.

## Interface
- N_MASTERS, 4: number of masters, 1..8.
- N_SLAVES, 6: number of slaves, 1..16.
- S_ADDR_W, 3: number of top address bits used for decode.
- S_ADDR, {3'b110,3'b101,3'b100,3'b010,3'b001,3'b000}: packed N_SLAVES*S_ADDR_W decode values; slave k occupies slice k.
- TIMEOUT, 255: maximum wait, in cycles, for an ack on a mapped slave; 0 disables the watchdog.

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge.
- sys_rst  in  1  reset, synchronous and active-high.
- m_adr_i  in  32*N_MASTERS  master addresses, packed; master i occupies slice i.
- m_dat_i  in  32*N_MASTERS  master write data.
- m_sel_i  in  4*N_MASTERS  byte selects.
- m_cti_i  in  3*N_MASTERS  cycle type.
- m_we_i, m_cyc_i, m_stb_i  in  N_MASTERS  per-master control.
- m_dat_o  out  32  read data, broadcast to all masters.
- m_ack_o, m_err_o  out  N_MASTERS  per-master termination.
- s_adr_o  out  32  shared address.
- s_dat_o  out  32  shared write data.
- s_sel_o  out  4  shared byte selects.
- s_cti_o  out  3  shared cycle type.
- s_we_o  out  1  shared write enable.
- s_cyc_o, s_stb_o  out  N_SLAVES  per-slave control.
- s_dat_i  in  32*N_SLAVES  slave read data.
- s_ack_i  in  N_SLAVES  slave acks.
- grant_o  out  N_MASTERS  one-hot current owner; all zero when idle.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

## Operation
- Arbiter states: IDLE and OWN.
  - IDLE: if any m_cyc_i bit is set, grant the first requester scanning upward from (last+1) mod N_MASTERS. The grant is registered, then go to OWN.
  - OWN: hold the grant while the owner's m_cyc_i is high. When it drops, clear the grant on that edge and return to IDLE.
  - `last` resets to N_MASTERS-1, so master 0 has first priority after reset.
- Muxing: the owner's adr/dat/sel/cti/we drive the s_* buses. With no owner, every s_* output and m_ack_o/m_err_o bit is 0.
- Decode: slave k is selected when the owner's adr[31:32-S_ADDR_W] equals S_ADDR slice k. If several slices match, the lowest k wins.
  - s_cyc_o[k] is the owner's cyc AND the decode hit for k.
  - s_stb_o[k] is the owner's stb AND the decode hit for k.
  - m_dat_o is s_dat_i of the selected slave, or 0 on a decode miss.
  - m_ack_o[owner] is s_ack_i of the selected slave. Acks from non-selected slaves are ignored.
- Decode miss: the owner's stb is high and no slice matches. The registered m_err_o[owner] pulses for one cycle, then stays low for one cycle. The pulse repeats while stb stays high.
- Watchdog: a 16-bit counter increments each cycle the owner's stb is high without ack or err. It clears on ack, err, stb low, or a grant change.
  - When count == TIMEOUT, on the next edge m_err_o[owner] and timeout_o pulse for one cycle, and the counter clears.
  - The selected slave's s_stb_o is forced low during that error cycle.
- Simultaneous ack and watchdog expiry in the same cycle: ack wins and no err is issued.
- Reset mid-transfer: on the next edge the grant clears, the counter clears and all outputs go to 0. Outstanding transfers are abandoned.

## Timing
- Grant latency: s_cyc_o/s_stb_o rise 1 cycle after m_cyc_i rises in IDLE.
- Data and ack path: m_ack_o and m_dat_o follow s_ack_i and s_dat_i combinationally, with 0 added latency.
- Bus turnaround: the owner drops cyc in cycle t. grant_o is 0 during t+1, and a new grant is visible in t+2.
- Decode-miss error latency: 1 cycle after stb.
- Watchdog error: TIMEOUT+1 cycles after stb when no ack arrives.
- Burst transfers (cti 3'b010) are held under a single grant. The arbiter does not interleave masters mid-cycle.

## Test plan
- Single master reads 0x40000010. Slave 2 acks after 3 cycles with 0xDEADBEEF. Expect grant_o=0001 one cycle after cyc, s_stb_o=000100, and m_ack_o[0] together with m_dat_o=0xDEADBEEF in the same cycle as s_ack_i[2].
- Masters 0, 1 and 3 assert cyc continuously, each dropping it after 1 transfer. Expect grant order 0,1,3,0,1,3 with 1 idle cycle between grants.
- Master 0 accesses 0x60000000, which has no slice. Expect m_err_o[0] one cycle after stb, no s_stb_o bit set, and m_dat_o=0.
- TIMEOUT=15 and slave 4 never acks. Expect m_err_o[0] and timeout_o 16 cycles after stb, then s_stb_o[4] low for that cycle.
- Slave acks in exactly the cycle the count reaches TIMEOUT. Expect ack only, no err and no timeout_o.
- Assert sys_rst mid-burst. Expect all outputs 0 on the next edge, and master 0 granted first after release.
